// File: rtl/fetch_dual.sv
// Dual-word instruction fetch: drives pc/pc+1 into a dual-port imem, buffers words in a small queue for decode.
// Optional FETCH_SKIP_NOP_EN: all-zero words are dropped instead of enqueued.
module fetch_dual #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] dir,
    output logic [ADDR_W-1:0] dir2,
    input  logic [DATA_W-1:0] ins,
    input  logic [DATA_W-1:0] ins2,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ins,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] ins;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [CNT_W-1:0]  free;
    logic              can_fetch;
    logic              keep0, keep1;
    logic              wr0, wr1;
    logic [1:0]        enq_n;
    logic              deq;
    logic [PTR_W-1:0]  wr1_idx;

    assign dir  = pc_q;
    assign dir2 = pc_q + ADDR_W'(1);

`ifdef FETCH_SKIP_NOP_EN
    assign keep0 = (ins  != '0);
    assign keep1 = (ins2 != '0);
`else
    assign keep0 = 1'b1;
    assign keep1 = 1'b1;
`endif

    // Space is judged on the registered count only, so a same-cycle dequeue never frees room.
    assign free      = CNT_W'(DEPTH) - count_q;
    assign can_fetch = (free >= CNT_W'(2));
    assign wr0       = !redirect && can_fetch && keep0;
    assign wr1       = !redirect && can_fetch && keep1;
    assign enq_n     = {1'b0, wr0} + {1'b0, wr1};
    assign deq       = out_valid && out_ready;
    assign wr1_idx   = wr0 ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;

    assign out_valid = (count_q != '0);
    assign out_ins   = out_valid ? mem_q[rd_ptr_q].ins : '0;
    assign out_pc    = out_valid ? mem_q[rd_ptr_q].pc  : '0;

    // Next-state: redirect flushes and reloads; otherwise fetch a pair when two slots are free.
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (can_fetch) begin
                pc_d = pc_q + ADDR_W'(2);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
            count_d  = count_q + CNT_W'(enq_n) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr0) begin
            mem_q[wr_ptr_q] <= '{ins: ins, pc: pc_q};
        end
        if (wr1) begin
            mem_q[wr1_idx] <= '{ins: ins2, pc: pc_q + ADDR_W'(1)};
        end
    end

endmodule

// File: doc/fetch_dual.md
# fetch_dual

Dual-word instruction fetch stage sitting directly upstream of the dual-read-port instruction memory. It holds the program counter and drives both memory addresses (`pc`, `pc+1`) every cycle. It captures the two returned words into a small instruction queue and presents them one per cycle to decode over a valid/ready handshake. A redirect input (branch/jump from downstream) flushes the queue and reloads the PC.

## Interface
- `ADDR_W`, 5: instruction address width; PC and memory address width.
- `DATA_W`, 32: instruction word width.
- `DEPTH`, 4: queue entries; power of two, ≥ 2.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `dir` out ADDR_W: memory port-1 address, equals `pc`.
- `dir2` out ADDR_W: memory port-2 address, equals `(pc+1) mod 2^ADDR_W`.
- `ins` in DATA_W: word at `dir`, combinational, same cycle.
- `ins2` in DATA_W: word at `dir2`, combinational, same cycle.
- `redirect` in 1: flush and reload PC.
- `redirect_pc` in ADDR_W: new PC, sampled when `redirect`=1.
- `out_valid` out 1: queue head valid.
- `out_ready` in 1: decode accepts head.
- `out_ins` out DATA_W: head instruction.
- `out_pc` out ADDR_W: address of head instruction.

## Operation
- Registers:
  - `pc`: ADDR_W bits.
  - queue storage: DEPTH × {ins, pc}.
  - `rd_ptr`, `wr_ptr`: log2(DEPTH) bits each.
  - `count`: 0..DEPTH.
- `dir`/`dir2` are purely combinational from `pc`. All arithmetic is modulo 2^ADDR_W, so `pc`=31 gives `dir2`=0.
- Free space: `free = DEPTH − count`, using the registered `count` before any same-cycle dequeue (conservative; no bypass).
- Enqueue decision each cycle, in priority order:
  1. `redirect`=1: queue flushed (`rd_ptr`=`wr_ptr`=`count`=0), `pc ← redirect_pc`, nothing enqueued.
  2. `free` ≥ 2: enqueue {`ins`,`pc`} then {`ins2`,`pc+1`}, `pc ← pc+2`.
  3. Otherwise: hold `pc`, no enqueue.
- Dequeue: when `out_valid` && `out_ready`, `rd_ptr` advances. `count` updates as `count + enq − deq`.
- Redirect with simultaneous handshake: the transfer at that edge is complete and decode keeps that instruction. The queue is still fully flushed.
- `out_valid = (count != 0)`. `out_ins`/`out_pc` show the head entry; both are forced to 0 when `out_valid`=0.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `pc`=0, `count`=0, pointers=0.
  - `out_valid`=0, `out_ins`=0, `out_pc`=0.
  - `dir`=0, `dir2`=1.
- Fetch latency: words addressed in cycle N are visible at the queue head from cycle N+1 at the earliest (1 cycle).
- Redirect: `dir` equals `redirect_pc` in the cycle after `redirect`. `out_valid` is 0 in that cycle, and the first redirected instruction is valid one cycle later.
- Throughput: 2 words/cycle in, 1 word/cycle out. With `out_ready` held high, the queue settles and fetch alternates between enqueue and hold cycles.
- Reset asserted mid-operation clears all state immediately. In-flight queue contents are discarded.
- `out_*` are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `FETCH_SKIP_NOP_EN`
  - Defined: words equal to 0 are not enqueued; `pc` still advances by 2. If one word is zero, only the other is written; if both are zero, nothing is written. The free-space check stays at ≥ 2.
  - Undefined: every fetched word is enqueued, including zeros.

## Test plan
- Reset, then `out_ready`=1, with memory holding 0x00221803 at 0 and 0x0C850001 at 1 → cycle 1: `out_valid`=1, `out_ins`=0x00221803, `out_pc`=0; next cycle 0x0C850001, `out_pc`=1.
- `out_ready`=0 for 6 cycles → `count` reaches 4, `pc` stops at 4, and `out_ins` stays 0x00221803. Release → words 0..3 leave in order, with no gaps or duplicates.
- `redirect`=1, `redirect_pc`=0x14 while queue is full → next cycle `out_valid`=0, `dir`=0x14, `dir2`=0x15. Following cycle `out_pc`=0x14, `out_ins`=0x10210000.
- `redirect_pc`=0x1F → `dir`=0x1F, `dir2`=0x00. The next PC is 0x01 and `out_pc` sequence is 0x1F, 0x00.
- Assert `reset` asynchronously mid-stream (between clock edges) → `out_valid`, `out_ins`, and `out_pc` drop to 0 immediately, and `dir`=0.
- With `FETCH_SKIP_NOP_EN`, run from PC 0x0C with 0x0D and 0x0E zero and 0x0F = 0x20000014 → `out_pc` sequence 0x0C, 0x0F. Without the macro → 0x0C, 0x0D, 0x0E, 0x0F.
